gpr_wb_scheduler: RTL and testbench



---
 rtl/gpr_wb_scheduler.sv | 118 +++++++++++
 tb/tb_gpr_wb_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_scheduler.sv
// GPR write-port scheduler: busy scoreboard for long-latency destinations,
// RAW/WAW stall generation for ID, and pipe/LL write-port arbitration with a starvation guard.
module gpr_wb_scheduler #(
    parameter int XLEN     = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid_i,
    input  logic [4:0]      id_rs1_i,
    input  logic [4:0]      id_rs2_i,
    input  logic [4:0]      id_rd_i,
    input  logic            id_rd_wen_i,
    input  logic            id_long_i,
    output logic            id_stall_o,
    input  logic            pipe_wb_valid_i,
    input  logic [4:0]      pipe_wb_addr_i,
    input  logic [XLEN-1:0] pipe_wb_data_i,
    output logic            pipe_hold_o,
    input  logic            ll_wb_valid_i,
    input  logic [4:0]      ll_wb_addr_i,
    input  logic [XLEN-1:0] ll_wb_data_i,
    output logic            ll_wb_ready_o,
    output logic            reg_wen_o,
    output logic [4:0]      reg_waddr_o,
    output logic [XLEN-1:0] reg_wdata_o,
    output logic [31:0]     busy_o
);
    typedef enum logic {ARB_PIPE, ARB_FORCE} state_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_nxt, wait_inc;
    logic [31:0] busy, busy_set, busy_clr, busy_nxt;
    logic        pipe_grant, ll_grant, hold, raw_waw, issue;

    assign raw_waw    = busy[id_rs1_i] | busy[id_rs2_i] | (id_rd_wen_i & busy[id_rd_i]);
    assign id_stall_o = !rst & id_valid_i & raw_waw;
    assign issue      = id_valid_i & !id_stall_o & id_rd_wen_i & id_long_i & (id_rd_i != 5'd0);
    assign wait_inc   = wait_cnt + 4'd1;

    always_comb begin
        pipe_grant = 1'b0;
        ll_grant   = 1'b0;
        hold       = 1'b0;
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        case (state)
            ARB_PIPE: begin
                if (pipe_wb_valid_i) begin
                    pipe_grant = 1'b1;
                    if (ll_wb_valid_i) begin
                        wait_nxt = wait_inc;
                        if (wait_inc == MAX_W) state_nxt = ARB_FORCE;
                    end
                end else if (ll_wb_valid_i) begin
                    ll_grant = 1'b1;
                    wait_nxt = 4'd0;
                end
            end
            ARB_FORCE: begin
                state_nxt = ARB_PIPE;
                wait_nxt  = 4'd0;
                // With the LL request gone the forced slot is released to the pipe immediately.
                if (ll_wb_valid_i) begin
                    ll_grant = 1'b1;
                    hold     = 1'b1;
                end else begin
                    pipe_grant = pipe_wb_valid_i;
                end
            end
            default: begin
                state_nxt = ARB_PIPE;
                wait_nxt  = 4'd0;
            end
        endcase
        if (rst) begin
            pipe_grant = 1'b0;
            ll_grant   = 1'b0;
            hold       = 1'b0;
        end
    end

    always_comb begin
        reg_waddr_o = 5'd0;
        reg_wdata_o = '0;
        if (ll_grant) begin
            reg_waddr_o = ll_wb_addr_i;
            reg_wdata_o = ll_wb_data_i;
        end else if (pipe_grant) begin
            reg_waddr_o = pipe_wb_addr_i;
            reg_wdata_o = pipe_wb_data_i;
        end
    end

    assign reg_wen_o     = (ll_grant | pipe_grant) & (reg_waddr_o != 5'd0);
    assign ll_wb_ready_o = ll_grant;
    assign pipe_hold_o   = hold;
    assign busy_o        = rst ? 32'd0 : busy;

    // Set is applied after clear so a same-index collision resolves to busy.
    assign busy_set = issue    ? (32'd1 << id_rd_i)      : 32'd0;
    assign busy_clr = ll_grant ? (32'd1 << ll_wb_addr_i) : 32'd0;
    assign busy_nxt = ((busy & ~busy_clr) | busy_set) & ~32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_PIPE;
            wait_cnt <= 4'd0;
            busy     <= 32'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            busy     <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_gpr_wb_scheduler.sv
// Directed, table-driven bench for gpr_wb_scheduler: one table row per clock cycle,
// followed by a hand-written starvation-guard sequence.
module tb_gpr_wb_scheduler;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid_i, id_rd_wen_i, id_long_i, id_stall_o;
    logic [4:0]      id_rs1_i, id_rs2_i, id_rd_i;
    logic            pipe_wb_valid_i, pipe_hold_o;
    logic [4:0]      pipe_wb_addr_i;
    logic [XLEN-1:0] pipe_wb_data_i;
    logic            ll_wb_valid_i, ll_wb_ready_o;
    logic [4:0]      ll_wb_addr_i;
    logic [XLEN-1:0] ll_wb_data_i;
    logic            reg_wen_o;
    logic [4:0]      reg_waddr_o;
    logic [XLEN-1:0] reg_wdata_o;
    logic [31:0]     busy_o;

    int checks   = 0;
    int failures = 0;

    gpr_wb_scheduler #(.XLEN(XLEN), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rd_i(id_rd_i), .id_rd_wen_i(id_rd_wen_i), .id_long_i(id_long_i),
        .id_stall_o(id_stall_o),
        .pipe_wb_valid_i(pipe_wb_valid_i), .pipe_wb_addr_i(pipe_wb_addr_i),
        .pipe_wb_data_i(pipe_wb_data_i), .pipe_hold_o(pipe_hold_o),
        .ll_wb_valid_i(ll_wb_valid_i), .ll_wb_addr_i(ll_wb_addr_i),
        .ll_wb_data_i(ll_wb_data_i), .ll_wb_ready_o(ll_wb_ready_o),
        .reg_wen_o(reg_wen_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            idv;
        logic [4:0]      rs1, rs2, rd;
        logic            rwen, lng;
        logic            pv;
        logic [4:0]      pa;
        logic [XLEN-1:0] pd;
        logic            lv;
        logic [4:0]      la;
        logic [XLEN-1:0] ld;
        logic            e_stall, e_hold, e_ready, e_wen;
        logic [4:0]      e_waddr;
        logic [XLEN-1:0] e_wdata;
        logic [31:0]     e_busy;
    } row_t;

    row_t rows[$];

    function automatic row_t mk(
        input logic rst_v,
        input logic idv, input int rs1, input int rs2, input int rd, input logic rwen, input logic lng,
        input logic pv, input int pa, input logic [XLEN-1:0] pd,
        input logic lv, input int la, input logic [XLEN-1:0] ld,
        input logic es, input logic eh, input logic er, input logic ew, input int ea,
        input logic [XLEN-1:0] ed, input logic [31:0] eb);
        row_t r;
        r.rst = rst_v; r.idv = idv; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
        r.rwen = rwen; r.lng = lng;
        r.pv = pv; r.pa = 5'(pa); r.pd = pd;
        r.lv = lv; r.la = 5'(la); r.ld = ld;
        r.e_stall = es; r.e_hold = eh; r.e_ready = er; r.e_wen = ew;
        r.e_waddr = 5'(ea); r.e_wdata = ed; r.e_busy = eb;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input row_t r);
        rst = r.rst;
        id_valid_i = r.idv; id_rs1_i = r.rs1; id_rs2_i = r.rs2; id_rd_i = r.rd;
        id_rd_wen_i = r.rwen; id_long_i = r.lng;
        pipe_wb_valid_i = r.pv; pipe_wb_addr_i = r.pa; pipe_wb_data_i = r.pd;
        ll_wb_valid_i = r.lv; ll_wb_addr_i = r.la; ll_wb_data_i = r.ld;
    endtask

    initial begin
        int pipe_wins;
        bit got_ready;
        // reset with busy-looking traffic on every input
        rows.push_back(mk(1, 1,5,5,5,1,1, 1,3,'h55, 1,4,'h44, 0,0,0,0,0,0,0));
        rows.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        // long issue to x5, RAW stall, LL clear with no bypass
        rows.push_back(mk(0, 1,0,0,5,1,1, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        rows.push_back(mk(0, 1,5,0,6,1,0, 0,0,0, 0,0,0, 1,0,0,0,0,0,'h20));
        rows.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,'h20));
        rows.push_back(mk(0, 1,5,0,0,0,0, 0,0,0, 1,5,'hDEAD, 1,0,1,1,5,'hDEAD,'h20));
        rows.push_back(mk(0, 1,5,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        // pipe+LL contention: four pipe wins then the forced LL slot
        for (int i = 0; i < 4; i++)
            rows.push_back(mk(0, 0,0,0,0,0,0, 1,10,'h100+i, 1,11,'hBB, 0,0,0,1,10,'h100+i,0));
        rows.push_back(mk(0, 0,0,0,0,0,0, 1,10,'h104, 1,11,'hBB, 0,1,1,1,11,'hBB,0));
        rows.push_back(mk(0, 0,0,0,0,0,0, 1,10,'h104, 0,0,0, 0,0,0,1,10,'h104,0));
        // wait counter restarted after the forced grant
        for (int i = 0; i < 4; i++)
            rows.push_back(mk(0, 0,0,0,0,0,0, 1,10,'h200+i, 1,12,'hCC, 0,0,0,1,10,'h200+i,0));
        rows.push_back(mk(0, 0,0,0,0,0,0, 1,10,'h204, 1,12,'hCC, 0,1,1,1,12,'hCC,0));
        rows.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        // an uncontested LL grant clears the counter
        rows.push_back(mk(0, 0,0,0,0,0,0, 1,10,'h300, 1,13,'hD0, 0,0,0,1,10,'h300,0));
        rows.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 1,13,'hD0, 0,0,1,1,13,'hD0,0));
        for (int i = 0; i < 4; i++)
            rows.push_back(mk(0, 0,0,0,0,0,0, 1,10,'h310+i, 1,14,'hE0, 0,0,0,1,10,'h310+i,0));
        rows.push_back(mk(0, 0,0,0,0,0,0, 1,10,'h314, 1,14,'hE0, 0,1,1,1,14,'hE0,0));
        // LL write to x0: handshake without write enable
        rows.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 1,0,'h1234, 0,0,1,0,0,'h1234,0));
        rows.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        // long issue to x0 ignored; WAW on x7; rd without write-enable; idle ID
        rows.push_back(mk(0, 1,0,0,0,1,1, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        rows.push_back(mk(0, 1,0,0,7,1,1, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        rows.push_back(mk(0, 1,0,0,7,1,1, 0,0,0, 0,0,0, 1,0,0,0,0,0,'h80));
        rows.push_back(mk(0, 1,0,0,7,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,'h80));
        rows.push_back(mk(0, 0,7,0,0,0,0, 0,0,0, 1,7,'h77, 0,0,1,1,7,'h77,'h80));
        // reset while in the forced-LL state with x9 busy
        rows.push_back(mk(0, 1,0,0,9,1,1, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        for (int i = 0; i < 4; i++)
            rows.push_back(mk(0, 0,0,0,0,0,0, 1,1,'h10+i, 1,9,'h99, 0,0,0,1,1,'h10+i,'h200));
        rows.push_back(mk(1, 0,0,0,0,0,0, 1,1,'h14, 1,9,'h99, 0,0,0,0,0,0,0));
        for (int i = 0; i < 4; i++)
            rows.push_back(mk(0, 0,0,0,0,0,0, 1,1,'h20+i, 1,9,'h99, 0,0,0,1,1,'h20+i,0));
        rows.push_back(mk(0, 0,0,0,0,0,0, 1,1,'h24, 1,9,'h99, 0,1,1,1,9,'h99,0));
        // same-cycle clear of x3 and read of x3 through rs2
        rows.push_back(mk(0, 1,0,0,3,1,1, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        rows.push_back(mk(0, 1,0,3,0,0,0, 0,0,0, 1,3,'h33, 1,0,1,1,3,'h33,'h8));
        rows.push_back(mk(0, 1,0,3,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        rows.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));

        for (int i = 0; i < rows.size(); i++) begin
            @(negedge clk);
            drive(rows[i]);
            #1;
            chk("id_stall",  i, 64'(id_stall_o),    64'(rows[i].e_stall));
            chk("pipe_hold", i, 64'(pipe_hold_o),   64'(rows[i].e_hold));
            chk("ll_ready",  i, 64'(ll_wb_ready_o), 64'(rows[i].e_ready));
            chk("reg_wen",   i, 64'(reg_wen_o),     64'(rows[i].e_wen));
            chk("reg_waddr", i, 64'(reg_waddr_o),   64'(rows[i].e_waddr));
            chk("reg_wdata", i, reg_wdata_o,        rows[i].e_wdata);
            chk("busy",      i, 64'(busy_o),        64'(rows[i].e_busy));
        end

        // Continuous contention: LL must get in after exactly MAX_WAIT pipe wins.
        pipe_wins = 0;
        got_ready = 0;
        for (int c = 0; c < 10 && !got_ready; c++) begin
            @(negedge clk);
            rst = 0; id_valid_i = 0;
            pipe_wb_valid_i = 1; pipe_wb_addr_i = 5'd20; pipe_wb_data_i = 64'h500 + 64'(c);
            ll_wb_valid_i = 1;   ll_wb_addr_i = 5'd21;   ll_wb_data_i = 64'hFACE;
            #1;
            if (ll_wb_ready_o) begin
                got_ready = 1;
                chk("force_waddr", c, 64'(reg_waddr_o), 64'd21);
                chk("force_hold",  c, 64'(pipe_hold_o), 64'd1);
            end else begin
                pipe_wins++;
            end
        end
        chk("force_seen", 0, 64'(got_ready), 64'd1);
        chk("pipe_wins",  0, 64'(pipe_wins), 64'd4);
        @(negedge clk);
        pipe_wb_valid_i = 0; ll_wb_valid_i = 0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
